// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger: single-pin ping sensor front end (trigger, echo timing, inch conversion).
// Define US_MEDIAN_FILTER_EN to report the median of the last three results instead of the raw one.
module ultrasonic_ranger #(
  parameter int TRIG_CYCLES = 250,
  parameter int HOLDOFF_CYCLES = 37500,
  parameter int CYCLES_PER_INCH = 7400,
  parameter int ECHO_TIMEOUT_CYCLES = 1000000,
  parameter int INTERVAL_CYCLES = 3000000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       EN,
  inout  logic       US,
  output logic [7:0] DISTANCE,
  output logic       VALID,
  output logic       TIMEOUT,
  output logic       BUSY
);
  localparam int PW = $clog2((TRIG_CYCLES > HOLDOFF_CYCLES ? TRIG_CYCLES : HOLDOFF_CYCLES) + 1);
  localparam int SW = $clog2(CYCLES_PER_INCH + 1);
  localparam int TW = $clog2(ECHO_TIMEOUT_CYCLES + 1);
  localparam int IW = $clog2(INTERVAL_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, TRIG, HOLDOFF, WAIT_ECHO, MEASURE, DONE} state_t;
  state_t state;
  logic [PW-1:0] pcnt;
  logic [SW-1:0] pre;
  logic [TW-1:0] tcnt;
  logic [IW-1:0] ivl;
  logic [7:0] inch, inch_nxt, result, raw;
  logic first, drive, timed_out, s1, s2, s3, rise, fall, pre_wrap, ivl_sat, tmo;
  assign US = drive ? 1'b1 : 1'bz;
  assign BUSY = state != IDLE;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
  assign pre_wrap = pre == SW'(CYCLES_PER_INCH - 1);
  assign ivl_sat = ivl == IW'(INTERVAL_CYCLES - 1);
  assign tmo = tcnt == TW'(ECHO_TIMEOUT_CYCLES - 1);
  // The cycle that sees the falling edge still counts as echo-high time.
  assign inch_nxt = (pre_wrap && inch != 8'hFF) ? inch + 8'd1 : inch;
  assign raw = timed_out ? 8'hFF : result;
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= US;
      s2 <= s1;
      s3 <= s2;
    end
  end
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state <= IDLE;
      pcnt <= '0;
      pre <= '0;
      tcnt <= '0;
      ivl <= '0;
      inch <= '0;
      result <= '0;
      first <= 1'b1;
      drive <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      if (!ivl_sat) ivl <= ivl + 1'b1;
      case (state)
        IDLE:
          if (EN && (first || ivl_sat)) begin
            state <= TRIG;
            drive <= 1'b1;
            pcnt <= '0;
            ivl <= '0;
            first <= 1'b0;
          end
        TRIG:
          if (pcnt == PW'(TRIG_CYCLES - 1)) begin
            state <= HOLDOFF;
            drive <= 1'b0;
            pcnt <= '0;
          end else pcnt <= pcnt + 1'b1;
        HOLDOFF:
          if (pcnt == PW'(HOLDOFF_CYCLES - 1)) begin
            state <= WAIT_ECHO;
            tcnt <= '0;
          end else pcnt <= pcnt + 1'b1;
        WAIT_ECHO:
          if (rise) begin
            state <= MEASURE;
            pre <= '0;
            inch <= '0;
            tcnt <= '0;
          end else if (tmo) begin
            state <= DONE;
            timed_out <= 1'b1;
          end else tcnt <= tcnt + 1'b1;
        MEASURE: begin
          pre <= pre_wrap ? '0 : pre + 1'b1;
          inch <= inch_nxt;
          if (fall) begin
            state <= DONE;
            result <= inch_nxt;
            timed_out <= 1'b0;
          end else if (tmo) begin
            state <= DONE;
            timed_out <= 1'b1;
          end else tcnt <= tcnt + 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef US_MEDIAN_FILTER_EN
  logic [7:0] h0, h1, h2, lo, hi, mid, med;
  logic pend, pend_to;
  always_comb begin
    lo = h0 < h1 ? h0 : h1;
    hi = h0 < h1 ? h1 : h0;
    mid = h2 < hi ? h2 : hi;
    med = mid > lo ? mid : lo;
  end
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      h0 <= 8'hFF;
      h1 <= 8'hFF;
      h2 <= 8'hFF;
      pend <= 1'b0;
      pend_to <= 1'b0;
      DISTANCE <= 8'hFF;
      VALID <= 1'b0;
      TIMEOUT <= 1'b0;
    end else begin
      pend <= state == DONE;
      VALID <= pend;
      if (state == DONE) begin
        h0 <= raw;
        h1 <= h0;
        h2 <= h1;
        pend_to <= timed_out;
      end
      if (pend) begin
        DISTANCE <= med;
        TIMEOUT <= pend_to;
      end
    end
  end
`else
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      DISTANCE <= 8'hFF;
      VALID <= 1'b0;
      TIMEOUT <= 1'b0;
    end else begin
      VALID <= state == DONE;
      if (state == DONE) begin
        DISTANCE <= raw;
        TIMEOUT <= timed_out;
      end
    end
  end
`endif
endmodule

// File: tb/tb_ultrasonic_ranger.sv
// tb_ultrasonic_ranger: sensor model driving the shared pin; directed table, random pings, reset aborts.
`timescale 1ns/1ps
module tb_ultrasonic_ranger;
  localparam int TRIG = 5, HOLD = 20, CPI = 3, TO = 1000, IVL = 1200;
`ifdef US_MEDIAN_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif
  typedef struct { int dly; int w; bit glitch; bit en_off; int exp_d; bit exp_to; } vec_t;
  logic clk = 0, rst_n = 0, en = 0, sens_en = 0;
  wire us;
  logic [7:0] distance;
  logic valid, timeout, busy;
  int checks = 0, errors = 0, cyc = 0, last_trig = -1;
  int hist[$];
  vec_t vecs[10];
  assign us = sens_en ? 1'b1 : 1'bz;
  pulldown (us);
  ultrasonic_ranger #(.TRIG_CYCLES(TRIG), .HOLDOFF_CYCLES(HOLD), .CYCLES_PER_INCH(CPI),
    .ECHO_TIMEOUT_CYCLES(TO), .INTERVAL_CYCLES(IVL)) dut (.CLK(clk), .RESET(rst_n), .EN(en),
    .US(us), .DISTANCE(distance), .VALID(valid), .TIMEOUT(timeout), .BUSY(busy));
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int model_raw(input int w);
    if (w == 0 || w > TO) return 255;
    return (w / CPI > 255) ? 255 : w / CPI;
  endfunction
  function automatic int expect_dist(input int raw);
    int s[$];
    hist.push_back(raw);
    if (hist.size() > 3) void'(hist.pop_front());
`ifdef US_MEDIAN_FILTER_EN
    s = hist;
    s.sort();
    return s[1];
`else
    return raw;
`endif
  endfunction
  task automatic wait_us(input logic val, input string name);
    int n = 0;
    while (us !== val && n < IVL + TO + 200) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(us === val), 1);
  endtask
  task automatic run_ping(input int dly, input int w, input bit glitch, input bit en_off,
                          input int exp_raw, input bit exp_to);
    int n, t0, tfall, vcyc, d, vto, vbusy, v_after, busy_cnt;
    bit got;
    wait_us(1'b1, "trig_seen");
    if (us !== 1'b1) return;
    t0 = cyc;
    if (last_trig >= 0) check("ping_period", (t0 - last_trig >= IVL) ? IVL : t0 - last_trig, IVL);
    last_trig = t0;
    n = 0;
    while (us === 1'b1 && n < TRIG + 10) begin
      @(negedge clk);
      n++;
    end
    check("trig_width", n, TRIG);
    check("busy_in_ping", int'(busy), 1);
    if (en_off) en = 0;
    tfall = cyc;
    fork
      begin
        repeat (3) @(negedge clk);
        sens_en = glitch;
        repeat (2) @(negedge clk);
        sens_en = 0;
        repeat (dly - 5) @(negedge clk);
        if (w > 0) begin
          sens_en = 1;
          repeat (w) @(negedge clk);
          sens_en = 0;
          tfall = cyc;
        end
      end
      begin
        n = 0;
        while (valid !== 1'b1 && n < HOLD + dly + w + TO + 100) begin
          @(negedge clk);
          n++;
        end
        got = valid === 1'b1;
        vcyc = cyc;
        d = distance;
        vto = timeout;
        vbusy = busy;
        @(negedge clk);
        v_after = valid;
      end
    join
    check("valid_seen", int'(got), 1);
    if (!got) return;
    if (w > 0 && !exp_to) check("valid_latency", vcyc - tfall, LAT);
    check("distance", d, expect_dist(exp_raw));
    check("timeout_flag", vto, int'(exp_to));
    check("valid_one_shot", v_after, 0);
`ifndef US_MEDIAN_FILTER_EN
    check("busy_after_done", vbusy, 0);
`endif
    if (en_off) begin
      busy_cnt = 0;
      repeat (IVL + 50) begin
        @(negedge clk);
        busy_cnt += int'(busy);
      end
      check("no_ping_when_disabled", busy_cnt, 0);
      en = 1;
    end
  endtask
  task automatic check_reset_state(input string tag);
    check({tag, "_distance"}, distance, 255);
    check({tag, "_valid"}, int'(valid), 0);
    check({tag, "_timeout"}, int'(timeout), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_pin"}, int'(us), 0);
  endtask
  initial begin
    int w, vcount;
    vecs[0] = '{30, 30, 0, 0, 10, 0};
    vecs[1] = '{30, 1100, 0, 1, 255, 1};
    vecs[2] = '{30, 0, 0, 0, 255, 1};
    vecs[3] = '{30, 6, 0, 0, 2, 0};
    vecs[4] = '{40, 2, 1, 0, 0, 0};
    vecs[5] = '{30, 3, 0, 0, 1, 0};
    vecs[6] = '{30, 900, 0, 0, 255, 0};
    vecs[7] = '{30, 150, 1, 0, 50, 0};
    vecs[8] = '{30, 36, 0, 0, 12, 0};
    vecs[9] = '{30, 33, 0, 0, 11, 0};
    hist = {255, 255, 255};
    repeat (5) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1;
    repeat (20) @(negedge clk);
    check("idle_without_en", int'(busy), 0);
    en = 1;
    foreach (vecs[i])
      run_ping(vecs[i].dly, vecs[i].w, vecs[i].glitch, vecs[i].en_off, vecs[i].exp_d, vecs[i].exp_to);
    for (int i = 0; i < 10; i++) begin
      w = $urandom_range(1, 990);
      run_ping($urandom_range(25, 80), w, 1'($urandom_range(0, 1)), 0, model_raw(w), w > TO);
    end
    wait_us(1'b1, "trig_before_reset");
    repeat (2) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    check_reset_state("reset_mid_trig");
    repeat (2) @(negedge clk);
    rst_n = 1;
    hist = {255, 255, 255};
    last_trig = -1;
    wait_us(1'b1, "trig_after_reset");
    wait_us(1'b0, "trig_release_after_reset");
    repeat (30) @(negedge clk);
    sens_en = 1;
    repeat (20) @(negedge clk);
    rst_n = 0;
    vcount = 0;
    repeat (5) begin
      @(negedge clk);
      vcount += int'(valid);
    end
    sens_en = 0;
    @(negedge clk);
    check("reset_mid_measure_no_valid", vcount, 0);
    check_reset_state("reset_mid_measure");
    rst_n = 1;
    hist = {255, 255, 255};
    last_trig = -1;
    run_ping(30, 30, 0, 0, 10, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ultrasonic_ranger.md
Name: ultrasonic_ranger

Overview:
- Front end for one single-pin ultrasonic ping sensor (trigger and echo share one bidirectional pin).
- Periodically fires a trigger pulse, releases the pin, times the echo pulse, and converts the width to whole inches as an 8-bit distance.
- Three instances feed the navigation block's DISTANCE_FRONT, DISTANCE_SIDE_FRONT and DISTANCE_SIDE_BACK inputs.
- Replaces ad-hoc ping timing with one verified stage.

Parameters:
- TRIG_CYCLES, 250: trigger high width in CLK cycles (5 us at 50 MHz).
- HOLDOFF_CYCLES, 37500: delay after trigger release before echo is accepted (750 us).
- CYCLES_PER_INCH, 7400: round-trip echo cycles per inch (148 us).
- ECHO_TIMEOUT_CYCLES, 1000000: maximum wait for echo rise, and maximum echo high time (20 ms).
- INTERVAL_CYCLES, 3000000: minimum start-to-start ping period (60 ms).

Ports:
- CLK  in  1  system clock, 50 MHz.
- RESET  in  1  synchronous, active-low reset.
- EN  in  1  ranging enable, sampled only in IDLE.
- US  inout  1  sensor pin; driven only during TRIG, high-Z otherwise.
- DISTANCE  out  8  last measured distance in inches, saturating at 255.
- VALID  out  1  one-cycle strobe when DISTANCE is updated.
- TIMEOUT  out  1  high if the last measurement timed out; cleared by the next good measurement.
- BUSY  out  1  high in every state except IDLE.

Behaviour:
- Reset (RESET=0 at a CLK edge):
  - State goes to IDLE; all counters clear; US released (high-Z).
  - DISTANCE=8'hFF, VALID=0, TIMEOUT=0, BUSY=0.
  - A reset mid-operation aborts immediately, including releasing the pin during TRIG.
- Echo input path:
  - Pin passes through a 2-flop synchronizer. All edge detection uses the synchronized value against its 1-cycle-delayed copy.
  - A pin edge is therefore acted on 3 cycles after it occurs.
- Interval counter:
  - Free-running from the TRIG entry of each ping, saturating at INTERVAL_CYCLES-1.
- State machine:
  - IDLE: when EN=1 and the interval counter is saturated (or this is the first ping after reset), go to TRIG.
  - TRIG: US driven 1 for exactly TRIG_CYCLES cycles, then released; go to HOLDOFF.
  - HOLDOFF: wait HOLDOFF_CYCLES; edges during this window are ignored. Go to WAIT_ECHO.
  - WAIT_ECHO:
    - On a synchronized rising edge, clear the prescaler and inch counter; go to MEASURE.
    - If ECHO_TIMEOUT_CYCLES elapse first, go to DONE with the timeout flag set.
  - MEASURE:
    - Prescaler counts 0..CYCLES_PER_INCH-1; on wrap, the inch counter increments, saturating at 255.
    - On a synchronized falling edge, go to DONE with result = inch counter (truncated, no rounding).
    - If the echo stays high for ECHO_TIMEOUT_CYCLES, go to DONE with the timeout flag set.
  - DONE (one cycle), then IDLE:
    - Good measurement: DISTANCE <= result, TIMEOUT <= 0.
    - Timeout: DISTANCE <= 8'hFF, TIMEOUT <= 1.
    - VALID=1 for this single cycle, coincident with the DISTANCE update.
- EN deasserted mid-ping: the current ping completes normally; no new ping starts.
- Latency: DISTANCE/VALID update 4 cycles after the pin's falling edge (2 sync + 1 detect + DONE).
- Counter widths: minimum bits to hold each parameter; the 20-bit timeout counter is shared by WAIT_ECHO and MEASURE and cleared on state entry.

Optional Feature:
- Macro US_MEDIAN_FILTER_EN.
- Defined:
  - A 3-entry history of raw results (timeouts enter as 255) is kept.
  - DISTANCE is the median of the last three, and the timed-out entry counts toward it. TIMEOUT reflects only the latest sample.
  - History is initialised to 255 at reset.
  - The median is registered, so DISTANCE/VALID move one cycle later: 5 cycles after the falling edge.
- Undefined: the raw result drives DISTANCE directly, as above.

Test Plan:
- Reset then EN=1, sensor model echoes 1480 us high after 1 ms -> TRIG pulse exactly 250 cycles; VALID once; DISTANCE=10; TIMEOUT=0; BUSY low after DONE.
- Echo width 40 ms (exceeds timeout) -> DISTANCE=255, TIMEOUT=1, VALID once, next ping starts no earlier than 3000000 cycles after the previous TRIG entry.
- No echo at all -> timeout after 1000000 WAIT_ECHO cycles; DISTANCE=255, TIMEOUT=1; next good echo of 296 us -> DISTANCE=2, TIMEOUT=0.
- Glitch on pin during HOLDOFF plus an echo of 7399 cycles -> glitch ignored; DISTANCE=0 (truncation).
- RESET=0 asserted mid-TRIG and mid-MEASURE -> pin high-Z at the next edge; DISTANCE=255; no VALID; normal ping restarts after release.
- With US_MEDIAN_FILTER_EN, sample sequence 10, 50, 12 -> DISTANCE 255, 50, 12. Sequence 10, 50, 12, 11 -> fourth DISTANCE=12; VALID 5 cycles after each falling edge.
